// File: rtl/matrix_stream_scheduler_if.sv
// Valid/ready pixel source feeding the frame scheduler.
interface matrix_stream_scheduler_if;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;

  modport master (output src_valid, output src_data, input src_ready);
  modport slave  (input src_valid, input src_data, output src_ready);
endinterface

// File: rtl/matrix_stream_scheduler.sv
// Frame sequencer: pulls gray pixels from a valid/ready source and emits
// vsync/href/gray with programmable blanking plus zero-data flush lines.
module matrix_stream_scheduler #(
  parameter int unsigned IMG_HDISP   = 640,
  parameter int unsigned IMG_VDISP   = 480,
  parameter int unsigned H_BLANK     = 16,
  parameter int unsigned V_PRE       = 4,
  parameter int unsigned V_BP        = 8,
  parameter int unsigned V_FP        = 8,
  parameter int unsigned FLUSH_LINES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            cont_en,
  matrix_stream_scheduler_if.slave        src_if,
  output logic                            per_frame_vsync,
  output logic                            per_frame_href,
  output logic [7:0]                      per_img_Gray,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            underflow
);

  typedef enum logic [2:0] {IDLE, PRE, VBP, HBL, LINE, VFP} state_t;

  localparam logic [10:0] COL_LAST = 11'(IMG_HDISP - 1);
  localparam logic [10:0] ROWS_IMG = 11'(IMG_VDISP);
  localparam logic [10:0] ROWS_ALL = 11'(IMG_VDISP + FLUSH_LINES);
  localparam logic [15:0] PRE_LAST = 16'(V_PRE - 1);
  localparam logic [15:0] BP_LAST  = 16'(V_BP - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] FP_LAST  = 16'(V_FP - 1);

  state_t      state_q, state_d;
  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic [15:0] gen_q, gen_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  gray_q, gray_d;
  logic        uf_q, uf_d;
  logic        img_row;

  assign img_row          = (row_q < ROWS_IMG);
  assign src_if.src_ready = (state_q == LINE) && img_row;
  assign busy             = (state_q != IDLE);
  assign frame_done       = (state_q == VFP) && (gen_q == FP_LAST);

  assign per_frame_vsync  = vsync_q;
  assign per_frame_href   = href_q;
  assign per_img_Gray     = gray_q;
  assign underflow        = uf_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gen_d   = gen_q;
    uf_d    = uf_q;
    vsync_d = 1'b0;
    href_d  = 1'b0;
    gray_d  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRE;
          gen_d   = '0;
          row_d   = '0;
          uf_d    = 1'b0;
        end
      end
      PRE: begin
        if (gen_q == PRE_LAST) begin
          state_d = VBP;
          gen_d   = '0;
        end else begin
          gen_d = gen_q + 16'd1;
        end
      end
      VBP: begin
        vsync_d = 1'b1;
        if (gen_q == BP_LAST) begin
          state_d = HBL;
          gen_d   = '0;
        end else begin
          gen_d = gen_q + 16'd1;
        end
      end
      HBL: begin
        vsync_d = 1'b1;
        // Timer saturates while an image row waits for the source.
        if (gen_q >= HB_LAST) begin
          if (!img_row || src_if.src_valid) begin
            state_d = LINE;
            col_d   = '0;
          end
        end else begin
          gen_d = gen_q + 16'd1;
        end
      end
      LINE: begin
        vsync_d = 1'b1;
        href_d  = 1'b1;
        if (img_row) begin
          if (src_if.src_valid) begin
            gray_d = src_if.src_data;
          end else begin
            gray_d = gray_q;
            uf_d   = 1'b1;
          end
        end
        if (col_q == COL_LAST) begin
          row_d   = row_q + 11'd1;
          gen_d   = '0;
          state_d = ((row_q + 11'd1) < ROWS_ALL) ? HBL : VFP;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      VFP: begin
        if (gen_q == FP_LAST) begin
          state_d = cont_en ? PRE : IDLE;
          gen_d   = '0;
          row_d   = '0;
        end else begin
          gen_d = gen_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      gen_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      gray_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gen_q   <= gen_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      gray_q  <= gray_d;
      uf_q    <= uf_d;
    end
  end

endmodule

// File: tb/tb_matrix_stream_scheduler.sv
// Directed bench for matrix_stream_scheduler: frame-level behavioural model
// checked every cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_matrix_stream_scheduler;

  localparam int HD = 4, VD = 3, HB = 2, VPRE = 2, VBPC = 3, VFPC = 2, FL = 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont_en = 1'b0, start0 = 1'b0;
  logic vs, hr, uf, bz, fd, vs0, hr0, uf0, bz0, fd0;
  logic [7:0] gy, gy0;

  matrix_stream_scheduler_if sif();
  matrix_stream_scheduler_if sif0();

  matrix_stream_scheduler #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .V_PRE(VPRE),
    .V_BP(VBPC), .V_FP(VFPC), .FLUSH_LINES(FL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont_en(cont_en), .src_if(sif),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_img_Gray(gy),
    .busy(bz), .frame_done(fd), .underflow(uf));

  matrix_stream_scheduler #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .V_PRE(VPRE),
    .V_BP(VBPC), .V_FP(VFPC), .FLUSH_LINES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont_en(1'b0), .src_if(sif0),
    .per_frame_vsync(vs0), .per_frame_href(hr0), .per_img_Gray(gy0),
    .busy(bz0), .frame_done(fd0), .underflow(uf0));

  always #5 clk = ~clk;

  // ---------------- behavioural model (frame described as nested loops) ----
  logic       e_vs = 0, e_href = 0, e_uf = 0, e_busy = 0, e_ready = 0, e_done = 0;
  logic [7:0] e_gray = '0, md = '0;
  logic       mv = 0, mstart = 0, mcont = 0;
  bit         m_abort = 0;

  task automatic tick(input logic b, input logic r, input logic d);
    e_busy = b; e_ready = r; e_done = d;
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_abort = 1'b1;
    else begin mv = sif.src_valid; md = sif.src_data; mstart = start; mcont = cont_en; end
  endtask

  task automatic regs(input logic v, input logic h, input logic [7:0] g);
    e_vs = v; e_href = h; e_gray = g;
  endtask

  task automatic model_frames();
    do begin
      for (int i = 0; i < VPRE; i++) begin tick(1, 0, 0); if (m_abort) return; regs(0, 0, 0); end
      for (int i = 0; i < VBPC; i++) begin tick(1, 0, 0); if (m_abort) return; regs(1, 0, 0); end
      for (int r = 0; r < VD + FL; r++) begin
        int n;
        n = 0;
        forever begin
          tick(1, 0, 0); if (m_abort) return;
          regs(1, 0, 0);
          n++;
          if (n >= HB && (r >= VD || mv)) break;
        end
        for (int c = 0; c < HD; c++) begin
          tick(1, r < VD, 0); if (m_abort) return;
          if (r >= VD) regs(1, 1, 8'd0);
          else if (mv) regs(1, 1, md);
          else begin regs(1, 1, e_gray); e_uf = 1'b1; end
        end
      end
      for (int i = 0; i < VFPC; i++) begin
        tick(1, 0, i == VFPC - 1); if (m_abort) return; regs(0, 0, 0);
      end
    end while (mcont);
  endtask

  initial begin
    forever begin
      if (m_abort || !rst_n) begin
        regs(0, 0, 0); e_uf = 0; e_busy = 0; e_ready = 0; e_done = 0;
        wait (rst_n);
        m_abort = 1'b0;
      end
      tick(0, 0, 0);
      if (m_abort) continue;
      regs(0, 0, 0);
      if (mstart) begin e_uf = 1'b0; model_frames(); end
    end
  end

  // ---------------- stimulus, compare and monitor (single thread) ----------
  int tests = 0, fails = 0;
  int unsigned nxt = 1, nxt0 = 1, hs_cnt = 0, drop_at = 0, drop_len = 0, drop_rem = 0;
  bit drop_armed = 0, pend = 0, pend0 = 0, go = 0, go0 = 0;
  logic [7:0] gq[$], gq0[$];
  int blens[$], gaps[$], falls[$], bz_after[$], blens0[$], falls0[$];
  int busy_cyc = 0, fd_cnt = 0, busy0_cyc = 0, fd0_cnt = 0;
  int cur = 0, gap_run = 0, cur0 = 0;
  bit in_burst = 0, have_prev = 0, prev_fd = 0, in_burst0 = 0;
  int s_g, s_b, s_gap, s_fall, s_busy, s_fd, s_bza, s0_g, s0_b, s0_fall, s0_busy, s0_fd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic monitor();
    busy_cyc += int'(bz);
    fd_cnt   += int'(fd);
    if (prev_fd) bz_after.push_back(int'(bz));
    prev_fd = fd;
    if (hr) begin
      gq.push_back(gy);
      if (!in_burst && have_prev) gaps.push_back(gap_run);
      in_burst = 1; cur++;
    end else begin
      if (in_burst) begin
        blens.push_back(cur); falls.push_back(int'(vs));
        cur = 0; in_burst = 0; gap_run = 0; have_prev = 1;
      end
      if (vs) gap_run++;
      else begin gap_run = 0; have_prev = 0; end
    end
    busy0_cyc += int'(bz0);
    fd0_cnt   += int'(fd0);
    if (hr0) begin gq0.push_back(gy0); in_burst0 = 1; cur0++; end
    else if (in_burst0) begin
      blens0.push_back(cur0); falls0.push_back(int'(vs0)); cur0 = 0; in_burst0 = 0;
    end
  endtask

  task automatic step(input bit do_rst);
    @(posedge clk); #1;
    if (pend) begin nxt++; hs_cnt++; end
    if (pend0) nxt0++;
    if (drop_armed && hs_cnt == drop_at) begin drop_rem = drop_len; drop_armed = 0; end
    if (drop_rem > 0) begin sif.src_valid = 1'b0; drop_rem--; end
    else sif.src_valid = 1'b1;
    sif.src_data  = 8'(nxt);
    sif0.src_data = 8'(nxt0);
    start = go; go = 0;
    start0 = go0; go0 = 0;
    if (do_rst) begin
      chk("href before reset", hr, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("async rst vsync", vs, 1'b0);
      chk("async rst href", hr, 1'b0);
      chk("async rst gray", gy, 8'd0);
      chk("async rst src_ready", sif.src_ready, 1'b0);
      chk("async rst busy", bz, 1'b0);
    end
    @(negedge clk);
    chk("vsync", vs, e_vs);
    chk("href", hr, e_href);
    chk("gray", gy, e_gray);
    chk("underflow", uf, e_uf);
    chk("busy", bz, e_busy);
    chk("src_ready", sif.src_ready, e_ready);
    chk("frame_done", fd, e_done);
    monitor();
    pend  = sif.src_valid && sif.src_ready;
    pend0 = sif0.src_valid && sif0.src_ready;
  endtask

  task automatic snap();
    s_g = gq.size(); s_b = blens.size(); s_gap = gaps.size(); s_fall = falls.size();
    s_busy = busy_cyc; s_fd = fd_cnt; s_bza = bz_after.size();
    nxt = 1; hs_cnt = 0;
  endtask

  function automatic int expg(input int i, input bit st);
    if (i >= 12) return 0;
    if (!st || i < 2) return i + 1;
    if (i == 2) return 2;
    return i;
  endfunction

  task automatic check_frame(input string tag, input int gap0, input int busy_exp,
                             input int hs_exp, input logic uf_exp, input bit st);
    chk({tag, " pixels"}, gq.size() - s_g, 16);
    for (int i = 0; i < 16; i++)
      if (s_g + i < gq.size()) chk($sformatf("%s gray[%0d]", tag, i), gq[s_g + i], expg(i, st));
    chk({tag, " bursts"}, blens.size() - s_b, 4);
    for (int i = s_b; i < blens.size(); i++) chk({tag, " burst len"}, blens[i], 4);
    chk({tag, " gaps"}, gaps.size() - s_gap, 3);
    if (gaps.size() - s_gap == 3) begin
      chk({tag, " gap0"}, gaps[s_gap], gap0);
      chk({tag, " gap1"}, gaps[s_gap + 1], 2);
      chk({tag, " gap2"}, gaps[s_gap + 2], 2);
    end
    if (falls.size() - s_fall == 4) begin
      chk({tag, " vsync at href fall 2"}, falls[s_fall + 2], 1);
      chk({tag, " vsync at href fall 3"}, falls[s_fall + 3], 0);
    end
    chk({tag, " busy cycles"}, busy_cyc - s_busy, busy_exp);
    chk({tag, " frame_done pulses"}, fd_cnt - s_fd, 1);
    if (bz_after.size() > s_bza) chk({tag, " busy after done"}, bz_after[s_bza], 0);
    chk({tag, " handshakes"}, hs_cnt, hs_exp);
    chk({tag, " underflow"}, uf, uf_exp);
  endtask

  initial begin
    int n;
    sif.src_valid = 1'b1; sif.src_data = 8'd1;
    sif0.src_valid = 1'b1; sif0.src_data = 8'd1;
    repeat (2) step(0);
    #2 rst_n = 1'b1;
    step(0);
    chk("reset vsync", vs, 1'b0);
    chk("reset href", hr, 1'b0);
    chk("reset gray", gy, 8'd0);
    chk("reset busy", bz, 1'b0);
    chk("reset frame_done", fd, 1'b0);
    chk("reset underflow", uf, 1'b0);
    chk("reset src_ready", sif.src_ready, 1'b0);

    // 1: plain frame
    snap(); go = 1;
    repeat (45) step(0);
    check_frame("s1", 2, 31, 12, 1'b0, 0);

    // 2: source absent across the line-2 start
    snap(); drop_at = 4; drop_len = 5; drop_armed = 1; go = 1;
    repeat (50) step(0);
    check_frame("s2", 6, 35, 12, 1'b0, 0);

    // 3: one-cycle stall at pixel index 2 of line 1
    snap(); drop_at = 2; drop_len = 1; drop_armed = 1; go = 1;
    repeat (45) step(0);
    check_frame("s3", 2, 31, 11, 1'b1, 1);

    // 4: continuous mode over two frames, stray start mid-frame
    snap(); cont_en = 1; go = 1;
    for (int c = 0; c < 75; c++) begin
      if (c == 20 || c == 50) go = 1;
      if (c == 40) cont_en = 0;
      step(0);
    end
    chk("s4 frame_done pulses", fd_cnt - s_fd, 2);
    chk("s4 busy cycles", busy_cyc - s_busy, 62);
    chk("s4 pixels", gq.size() - s_g, 32);
    if (gq.size() - s_g == 32) begin
      chk("s4 frame2 first", gq[s_g + 16], 13);
      chk("s4 frame2 last", gq[s_g + 27], 24);
    end
    if (bz_after.size() - s_bza == 2) begin
      chk("s4 no idle between frames", bz_after[s_bza], 1);
      chk("s4 idle after frame2", bz_after[s_bza + 1], 0);
    end
    chk("s4 underflow cleared by start", uf, 1'b0);

    // 5: reset in row 1, then a full frame
    snap(); go = 1; n = 0;
    while (hs_cnt < 5 && n < 60) begin step(0); n++; end
    chk("s5 reached row 1", hs_cnt, 5);
    step(1);
    repeat (3) step(0);
    #2 rst_n = 1'b1;
    step(0);
    snap(); go = 1;
    repeat (45) step(0);
    check_frame("s5", 2, 31, 12, 1'b0, 0);

    // 6: no flush lines
    s0_g = gq0.size(); s0_b = blens0.size(); s0_fall = falls0.size();
    s0_busy = busy0_cyc; s0_fd = fd0_cnt; nxt0 = 1; go0 = 1;
    repeat (40) step(0);
    chk("s6 bursts", blens0.size() - s0_b, 3);
    chk("s6 pixels", gq0.size() - s0_g, 12);
    for (int i = 0; i < 12; i++)
      if (s0_g + i < gq0.size()) chk($sformatf("s6 gray[%0d]", i), gq0[s0_g + i], i + 1);
    if (falls0.size() - s0_fall == 3) begin
      chk("s6 vsync at href fall 1", falls0[s0_fall + 1], 1);
      chk("s6 vsync at href fall 2", falls0[s0_fall + 2], 0);
    end
    chk("s6 busy cycles", busy0_cyc - s0_busy, 25);
    chk("s6 frame_done pulses", fd0_cnt - s0_fd, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
